fpmul_arbiter: RTL and testbench

Shares one single-precision FP multiplier (fpmul) between N_REQ requesters using round-robin arbitration.
- Accepts operand/rounding-mode requests over valid/ready.
- Drives the multiplier's r_mode/fp_X/fp_Y from registered operands and waits a fixed latency.
- Captures fp_Z/ovrf/udrf and returns them to the granted requester over a valid/ready response channel.
- Sits between client datapaths and the fpmul instance; not pipelined, one operation in flight.

---
 rtl/fpmul_arbiter_pkg.sv | 22 ++
 rtl/fpmul_arbiter_if.sv | 36 +++
 rtl/fpmul_arbiter_rr_arbiter.sv | 39 +++
 rtl/fpmul_arbiter.sv | 165 ++++++++++++++++
 tb/tb_fpmul_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpmul_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpmul_arb_pkg
// Description : Shared types and constants for the round-robin arbiter that
//               time-shares one single-precision FP multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package fpmul_arb_pkg;

    localparam int FP_W  = 32;   // IEEE-754 single-precision word
    localparam int RM_W  = 3;    // rounding-mode field
    localparam int CNT_W = 16;   // exception event counters

    // Controller states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/fpmul_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fpmul_arbiter_if
// Description : Request/response bundle between N_REQ client datapaths and
//               the shared-multiplier arbiter. Client side drives requests
//               (master); the arbiter serves them (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface fpmul_arbiter_if #(
    parameter int N_REQ = 4
);
    import fpmul_arb_pkg::*;

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [FP_W*N_REQ-1:0] req_x;
    logic [FP_W*N_REQ-1:0] req_y;
    logic [RM_W*N_REQ-1:0] req_rmode;
    logic [N_REQ-1:0]      rsp_valid;
    logic [N_REQ-1:0]      rsp_ready;
    logic [FP_W-1:0]       rsp_z;
    logic                  rsp_ovrf;
    logic                  rsp_udrf;

    modport master (
        output req_valid, req_x, req_y, req_rmode, rsp_ready,
        input  req_ready, rsp_valid, rsp_z, rsp_ovrf, rsp_udrf
    );

    modport slave (
        input  req_valid, req_x, req_y, req_rmode, rsp_ready,
        output req_ready, rsp_valid, rsp_z, rsp_ovrf, rsp_udrf
    );

endinterface
`default_nettype wire

// File: rtl/fpmul_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Scans the request vector
//               starting at i_ptr and wrapping around; returns the first
//               asserted requester as one-hot grant plus its index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  wire logic [N-1:0]     i_req,
    input  wire logic [IDX_W-1:0] i_ptr,
    output logic      [N-1:0]     o_grant,
    output logic      [IDX_W-1:0] o_grant_idx,
    output logic                  o_grant_any
);

    logic [IDX_W-1:0] w_sel;

    // First requester at or after the pointer wins; later hits are masked
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_any = 1'b0;
        w_sel       = '0;
        for (int k = 0; k < N; k++) begin
            w_sel = IDX_W'((32'(i_ptr) + 32'(k)) % 32'(N));
            if (!o_grant_any && i_req[w_sel]) begin
                o_grant_any    = 1'b1;
                o_grant_idx    = w_sel;
                o_grant[w_sel] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpmul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpmul_arbiter
// Description : Shares one single-precision FP multiplier between N_REQ
//               requesters. Round-robin grant in IDLE, operands held at the
//               multiplier for MUL_LAT cycles in ISSUE, result returned to
//               the owner over a valid/ready response in RESP. One operation
//               in flight at a time.
//               Optional: FPMUL_ARB_EXC_CNT_EN enables saturating overflow /
//               underflow event counters (tied to zero otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module fpmul_arbiter
    import fpmul_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 2
) (
    input  wire logic             clk,
    input  wire logic             rstn,
    fpmul_arbiter_if.slave        bus,
    output logic      [RM_W-1:0]  mul_r_mode,
    output logic      [FP_W-1:0]  mul_fp_x,
    output logic      [FP_W-1:0]  mul_fp_y,
    input  wire logic [FP_W-1:0]  mul_fp_z,
    input  wire logic             mul_ovrf,
    input  wire logic             mul_udrf,
    output logic      [CNT_W-1:0] ovrf_cnt,
    output logic      [CNT_W-1:0] udrf_cnt
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int LAT_W = $clog2(MUL_LAT + 1);

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_owner;
    logic [LAT_W-1:0] r_cnt;
    logic [FP_W-1:0]  r_op_x;
    logic [FP_W-1:0]  r_op_y;
    logic [RM_W-1:0]  r_op_rmode;
    logic [N_REQ-1:0] r_rsp_valid;
    logic [FP_W-1:0]  r_rsp_z;
    logic             r_rsp_ovrf;
    logic             r_rsp_udrf;

    logic [N_REQ-1:0] w_grant;
    logic [IDX_W-1:0] w_grant_idx;
    logic             w_grant_any;
    logic [IDX_W-1:0] w_ptr_next;
    logic [N_REQ-1:0] w_owner_onehot;
    logic             w_capture;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_req       (bus.req_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_grant_any (w_grant_any)
    );

    // Pointer moves just past the winner, wrapping at N_REQ
    assign w_ptr_next = (w_grant_idx == IDX_W'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

    assign w_owner_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;
    assign w_capture      = (r_state == ISSUE) && (r_cnt == '0);

    // Ready only advertised in IDLE; forced low while reset is asserted
    assign bus.req_ready = (rstn && (r_state == IDLE)) ? w_grant : '0;

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_z     = r_rsp_z;
    assign bus.rsp_ovrf  = r_rsp_ovrf;
    assign bus.rsp_udrf  = r_rsp_udrf;

    // Multiplier inputs come straight from the operand registers so they stay
    // stable for the whole ISSUE window
    assign mul_fp_x   = r_op_x;
    assign mul_fp_y   = r_op_y;
    assign mul_r_mode = r_op_rmode;

    // Main controller: accept, issue for MUL_LAT cycles, hold response
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_cnt       <= '0;
            r_op_x      <= '0;
            r_op_y      <= '0;
            r_op_rmode  <= '0;
            r_rsp_valid <= '0;
            r_rsp_z     <= '0;
            r_rsp_ovrf  <= 1'b0;
            r_rsp_udrf  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_any) begin
                        r_op_x     <= bus.req_x[FP_W*w_grant_idx +: FP_W];
                        r_op_y     <= bus.req_y[FP_W*w_grant_idx +: FP_W];
                        r_op_rmode <= bus.req_rmode[RM_W*w_grant_idx +: RM_W];
                        r_owner    <= w_grant_idx;
                        r_rr_ptr   <= w_ptr_next;
                        r_cnt      <= LAT_W'(MUL_LAT - 1);
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_cnt == '0) begin
                        r_rsp_z     <= mul_fp_z;
                        r_rsp_ovrf  <= mul_ovrf;
                        r_rsp_udrf  <= mul_udrf;
                        r_rsp_valid <= w_owner_onehot;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready[r_owner]) begin
                        r_rsp_valid <= '0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef FPMUL_ARB_EXC_CNT_EN
    logic [CNT_W-1:0] r_ovrf_cnt;
    logic [CNT_W-1:0] r_udrf_cnt;

    // Count flagged results at capture time, saturating at all-ones
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovrf_cnt <= '0;
            r_udrf_cnt <= '0;
        end else if (w_capture) begin
            if (mul_ovrf && (r_ovrf_cnt != '1)) begin
                r_ovrf_cnt <= r_ovrf_cnt + 1'b1;
            end
            if (mul_udrf && (r_udrf_cnt != '1)) begin
                r_udrf_cnt <= r_udrf_cnt + 1'b1;
            end
        end
    end

    assign ovrf_cnt = r_ovrf_cnt;
    assign udrf_cnt = r_udrf_cnt;
`else
    logic w_unused;
    assign w_unused = w_capture;
    assign ovrf_cnt = '0;
    assign udrf_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpmul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpmul_arbiter
// Description : Directed self-checking bench for fpmul_arbiter with a small
//               table-driven multiplier model (one-cycle input register).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpmul_arbiter;

    logic        clk;
    logic        rstn;
    logic [2:0]  mul_r_mode;
    logic [31:0] mul_fp_x;
    logic [31:0] mul_fp_y;
    logic [31:0] mul_fp_z;
    logic        mul_ovrf;
    logic        mul_udrf;
    logic [15:0] ovrf_cnt;
    logic [15:0] udrf_cnt;
    logic [31:0] mdl_x;
    logic [31:0] mdl_y;

    int checks;
    int errors;

`ifdef FPMUL_ARB_EXC_CNT_EN
    localparam logic [15:0] EXP_CNT1 = 16'd1;
`else
    localparam logic [15:0] EXP_CNT1 = 16'd0;
`endif

    fpmul_arbiter_if #(.N_REQ(4)) arb_if ();

    fpmul_arbiter #(
        .N_REQ   (4),
        .MUL_LAT (2)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (arb_if),
        .mul_r_mode (mul_r_mode),
        .mul_fp_x   (mul_fp_x),
        .mul_fp_y   (mul_fp_y),
        .mul_fp_z   (mul_fp_z),
        .mul_ovrf   (mul_ovrf),
        .mul_udrf   (mul_udrf),
        .ovrf_cnt   (ovrf_cnt),
        .udrf_cnt   (udrf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: inputs registered once, result table-driven
    always @(posedge clk) begin
        mdl_x <= mul_fp_x;
        mdl_y <= mul_fp_y;
    end

    always_comb begin
        mul_fp_z = mdl_x ^ mdl_y;
        mul_ovrf = 1'b0;
        mul_udrf = 1'b0;
        if (mdl_x == 32'h3F800000 && mdl_y == 32'h40000000) mul_fp_z = 32'h40000000;
        if (mdl_x == 32'h40000000 && mdl_y == 32'h40000000) mul_fp_z = 32'h40800000;
        if (mdl_x == 32'h3FC00000 && mdl_y == 32'h40000000) mul_fp_z = 32'h40400000;
        if (mdl_x == 32'h40400000 && mdl_y == 32'h40400000) mul_fp_z = 32'h41100000;
        if (mdl_x == 32'h7F000000 && mdl_y == 32'h7F000000) begin
            mul_fp_z = 32'h7F800000;
            mul_ovrf = 1'b1;
        end
        if (mdl_x == 32'h00800000 && mdl_y == 32'h00800000) begin
            mul_fp_z = 32'h00000000;
            mul_udrf = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until a response appears or the budget runs out
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (arb_if.rsp_valid == 4'b0000 && lat < 12) begin
            tick();
            lat++;
        end
    endtask

    task automatic set_ops(input int i, input logic [31:0] x, input logic [31:0] y);
        arb_if.req_x[32*i +: 32] = x;
        arb_if.req_y[32*i +: 32] = y;
        arb_if.req_rmode[3*i +: 3] = 3'd0;
    endtask

    task automatic apply_reset();
        arb_if.req_valid = 4'b0000;
        arb_if.rsp_ready = 4'b0000;
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        arb_if.req_valid = 4'hF;
        arb_if.rsp_ready = 4'h0;
        arb_if.req_x = '0;
        arb_if.req_y = '0;
        arb_if.req_rmode = '0;
        rstn = 1'b0;
        tick();
        tick();
        checks++;
        if (arb_if.req_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_req_ready got %b exp 0000", arb_if.req_ready);
        end
        checks++;
        if (arb_if.rsp_valid !== 4'b0000 || arb_if.rsp_z !== 32'h0 || arb_if.rsp_ovrf !== 1'b0 || arb_if.rsp_udrf !== 1'b0) begin
            errors++; $display("FAIL reset_rsp got v=%b z=%h o=%b u=%b exp all 0", arb_if.rsp_valid, arb_if.rsp_z, arb_if.rsp_ovrf, arb_if.rsp_udrf);
        end
        checks++;
        if (mul_fp_x !== 32'h0 || mul_fp_y !== 32'h0 || mul_r_mode !== 3'h0) begin
            errors++; $display("FAIL reset_mul got x=%h y=%h rm=%h exp 0", mul_fp_x, mul_fp_y, mul_r_mode);
        end
        checks++;
        if (ovrf_cnt !== 16'h0 || udrf_cnt !== 16'h0) begin
            errors++; $display("FAIL reset_cnt got %h/%h exp 0/0", ovrf_cnt, udrf_cnt);
        end
        arb_if.req_valid = 4'b0000;
        rstn = 1'b1;
        #1;
    endtask

    task automatic test_basic();
        set_ops(0, 32'h3F800000, 32'h40000000);
        arb_if.req_valid = 4'b0001;
        arb_if.rsp_ready = 4'b0000;
        #1;
        checks++;
        if (arb_if.req_ready !== 4'b0001) begin
            errors++; $display("FAIL basic_ready got %b exp 0001", arb_if.req_ready);
        end
        tick();
        arb_if.req_valid = 4'b0010;
        #1;
        checks++;
        if (arb_if.req_ready !== 4'b0000) begin
            errors++; $display("FAIL basic_ready_issue got %b exp 0000", arb_if.req_ready);
        end
        checks++;
        if (mul_fp_x !== 32'h3F800000 || mul_fp_y !== 32'h40000000) begin
            errors++; $display("FAIL basic_mul_ops got %h %h exp 3f800000 40000000", mul_fp_x, mul_fp_y);
        end
        tick();
        checks++;
        if (arb_if.rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL basic_early_rsp got %b exp 0000", arb_if.rsp_valid);
        end
        tick();
        checks++;
        if (arb_if.rsp_valid !== 4'b0001 || arb_if.rsp_z !== 32'h40000000 || arb_if.rsp_ovrf !== 1'b0 || arb_if.rsp_udrf !== 1'b0) begin
            errors++; $display("FAIL basic_rsp got v=%b z=%h o=%b u=%b exp 0001 40000000 0 0", arb_if.rsp_valid, arb_if.rsp_z, arb_if.rsp_ovrf, arb_if.rsp_udrf);
        end
        arb_if.req_valid = 4'b0000;
        tick();
        checks++;
        if (arb_if.rsp_valid !== 4'b0001) begin
            errors++; $display("FAIL basic_rsp_hold got %b exp 0001", arb_if.rsp_valid);
        end
        arb_if.rsp_ready = 4'b0001;
        tick();
        checks++;
        if (arb_if.rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL basic_rsp_clear got %b exp 0000", arb_if.rsp_valid);
        end
        arb_if.rsp_ready = 4'b0000;
    endtask

    task automatic test_exceptions();
        int lat;
        // rr_ptr is 1 here; only req2 asks
        set_ops(2, 32'h7F000000, 32'h7F000000);
        arb_if.req_valid = 4'b0100;
        #1;
        checks++;
        if (arb_if.req_ready !== 4'b0100) begin
            errors++; $display("FAIL ovf_ready got %b exp 0100", arb_if.req_ready);
        end
        wait_rsp(lat);
        arb_if.req_valid = 4'b0000;
        checks++;
        if (lat != 3) begin
            errors++; $display("FAIL ovf_latency got %0d exp 3", lat);
        end
        checks++;
        if (arb_if.rsp_valid !== 4'b0100 || arb_if.rsp_z !== 32'h7F800000 || arb_if.rsp_ovrf !== 1'b1 || arb_if.rsp_udrf !== 1'b0) begin
            errors++; $display("FAIL ovf_rsp got v=%b z=%h o=%b u=%b exp 0100 7f800000 1 0", arb_if.rsp_valid, arb_if.rsp_z, arb_if.rsp_ovrf, arb_if.rsp_udrf);
        end
        arb_if.rsp_ready = 4'hF;
        tick();
        checks++;
        if (ovrf_cnt !== EXP_CNT1 || udrf_cnt !== 16'd0) begin
            errors++; $display("FAIL ovf_cnt got %h/%h exp %h/0000", ovrf_cnt, udrf_cnt, EXP_CNT1);
        end
        // rr_ptr is 3; req1 is found after wrapping
        arb_if.rsp_ready = 4'h0;
        set_ops(1, 32'h00800000, 32'h00800000);
        arb_if.req_valid = 4'b0010;
        #1;
        checks++;
        if (arb_if.req_ready !== 4'b0010) begin
            errors++; $display("FAIL udf_ready got %b exp 0010", arb_if.req_ready);
        end
        wait_rsp(lat);
        arb_if.req_valid = 4'b0000;
        checks++;
        if (arb_if.rsp_valid !== 4'b0010 || arb_if.rsp_z !== 32'h0 || arb_if.rsp_ovrf !== 1'b0 || arb_if.rsp_udrf !== 1'b1) begin
            errors++; $display("FAIL udf_rsp got v=%b z=%h o=%b u=%b exp 0010 00000000 0 1", arb_if.rsp_valid, arb_if.rsp_z, arb_if.rsp_ovrf, arb_if.rsp_udrf);
        end
        arb_if.rsp_ready = 4'hF;
        tick();
        checks++;
        if (ovrf_cnt !== EXP_CNT1 || udrf_cnt !== EXP_CNT1) begin
            errors++; $display("FAIL udf_cnt got %h/%h exp %h/%h", ovrf_cnt, udrf_cnt, EXP_CNT1, EXP_CNT1);
        end
        arb_if.rsp_ready = 4'h0;
    endtask

    task automatic test_round_robin();
        int lat;
        int who;
        logic [31:0] exp_z [4];
        exp_z[0] = 32'h40000000;
        exp_z[1] = 32'h40800000;
        exp_z[2] = 32'h40400000;
        exp_z[3] = 32'h41100000;
        apply_reset();
        set_ops(0, 32'h3F800000, 32'h40000000);
        set_ops(1, 32'h40000000, 32'h40000000);
        set_ops(2, 32'h3FC00000, 32'h40000000);
        set_ops(3, 32'h40400000, 32'h40400000);
        arb_if.req_valid = 4'hF;
        arb_if.rsp_ready = 4'hF;
        #1;
        for (int op = 0; op < 6; op++) begin
            who = op % 4;
            checks++;
            if (arb_if.req_ready !== (4'b0001 << who)) begin
                errors++; $display("FAIL rr_grant op%0d got %b exp %b", op, arb_if.req_ready, 4'b0001 << who);
            end
            wait_rsp(lat);
            checks++;
            if (lat != 3 || arb_if.rsp_valid !== (4'b0001 << who) || arb_if.rsp_z !== exp_z[who]) begin
                errors++; $display("FAIL rr_rsp op%0d got lat=%0d v=%b z=%h exp lat=3 v=%b z=%h", op, lat, arb_if.rsp_valid, arb_if.rsp_z, 4'b0001 << who, exp_z[who]);
            end
            tick();
        end
        arb_if.req_valid = 4'b0000;
        arb_if.rsp_ready = 4'h0;
        #1;
    endtask

    task automatic test_backpressure();
        int lat;
        // rr_ptr is 2 after six round-robin operations
        arb_if.req_valid = 4'b0010;
        #1;
        checks++;
        if (arb_if.req_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_grant1 got %b exp 0010", arb_if.req_ready);
        end
        tick();
        arb_if.req_valid = 4'b1001;
        arb_if.rsp_ready = 4'b1101;
        wait_rsp(lat);
        checks++;
        if (lat != 2) begin
            errors++; $display("FAIL bp_latency got %0d exp 2", lat);
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (arb_if.rsp_valid !== 4'b0010 || arb_if.rsp_z !== 32'h40800000 || arb_if.req_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_hold c%0d got v=%b z=%h rdy=%b exp 0010 40800000 0000", c, arb_if.rsp_valid, arb_if.rsp_z, arb_if.req_ready);
            end
            tick();
        end
        arb_if.rsp_ready = 4'hF;
        tick();
        checks++;
        if (arb_if.rsp_valid !== 4'b0000 || arb_if.req_ready !== 4'b1000) begin
            errors++; $display("FAIL bp_release got v=%b rdy=%b exp 0000 1000", arb_if.rsp_valid, arb_if.req_ready);
        end
        wait_rsp(lat);
        arb_if.req_valid = 4'b0000;
        checks++;
        if (arb_if.rsp_valid !== 4'b1000 || arb_if.rsp_z !== 32'h41100000) begin
            errors++; $display("FAIL bp_req3_rsp got v=%b z=%h exp 1000 41100000", arb_if.rsp_valid, arb_if.rsp_z);
        end
        tick();
        arb_if.rsp_ready = 4'h0;
    endtask

    task automatic test_reset_midop();
        int lat;
        // rr_ptr is 0; req2 wins as the only requester
        arb_if.req_valid = 4'b0100;
        #1;
        checks++;
        if (arb_if.req_ready !== 4'b0100) begin
            errors++; $display("FAIL rst_mid_grant got %b exp 0100", arb_if.req_ready);
        end
        tick();
        arb_if.req_valid = 4'b0101;
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (arb_if.rsp_valid !== 4'b0000 || arb_if.req_ready !== 4'b0000 || mul_fp_x !== 32'h0 || mul_fp_y !== 32'h0) begin
            errors++; $display("FAIL rst_mid_async got v=%b rdy=%b x=%h y=%h exp all 0", arb_if.rsp_valid, arb_if.req_ready, mul_fp_x, mul_fp_y);
        end
        tick();
        arb_if.req_valid = 4'b0000;
        tick();
        rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (arb_if.rsp_valid !== 4'b0000) begin
                errors++; $display("FAIL rst_mid_stale c%0d got %b exp 0000", c, arb_if.rsp_valid);
            end
        end
        arb_if.req_valid = 4'b0101;
        arb_if.rsp_ready = 4'hF;
        #1;
        checks++;
        if (arb_if.req_ready !== 4'b0001) begin
            errors++; $display("FAIL rst_mid_next_grant got %b exp 0001", arb_if.req_ready);
        end
        wait_rsp(lat);
        arb_if.req_valid = 4'b0000;
        checks++;
        if (lat != 3 || arb_if.rsp_valid !== 4'b0001 || arb_if.rsp_z !== 32'h40000000) begin
            errors++; $display("FAIL rst_mid_rsp got lat=%0d v=%b z=%h exp 3 0001 40000000", lat, arb_if.rsp_valid, arb_if.rsp_z);
        end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_exceptions();
        test_round_robin();
        test_backpressure();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
